// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit seven-segment display.
// Snapshots the digit word once per frame and scans active-low SEL/SEG lines.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV    = 49_999,
    parameter bit          SEP_AS_DASH = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    input  logic [31:0] Disp_Data,
    input  logic [7:0]  Blank_Mask,
    input  logic [7:0]  Dp_Mask,
    output logic [7:0]  SEL,
    output logic [7:0]  SEG,
    output logic        Frame_Done
);

    localparam int unsigned CntW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            load_pending_q, load_pending_d;
    logic [31:0]     shadow_data_q, shadow_data_d;
    logic [7:0]      shadow_blank_q, shadow_blank_d;
    logic [7:0]      shadow_dp_q, shadow_dp_d;
    logic [7:0]      sel_q, sel_d;
    logic [7:0]      seg_q, seg_d;
    logic            tick;
    logic            load;
    logic [3:0]      nibble;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = SEP_AS_DASH ? 7'h3F : 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick = En && (div_cnt_q == CntMax);
        // A pending load and the end-of-frame tick can coincide; both map to one snapshot.
        load = (tick && (idx_q == 3'd7)) || (load_pending_q && En);

        div_cnt_d      = (!En || div_cnt_q == CntMax) ? '0 : div_cnt_q + CntW'(1);
        idx_d          = !En ? 3'd0 : (tick ? idx_q + 3'd1 : idx_q);
        load_pending_d = !En ? 1'b1 : (load ? 1'b0 : load_pending_q);

        shadow_data_d  = load ? Disp_Data  : shadow_data_q;
        shadow_blank_d = load ? Blank_Mask : shadow_blank_q;
        shadow_dp_d    = load ? Dp_Mask    : shadow_dp_q;

        nibble = shadow_data_q[{idx_q, 2'b00} +: 4];
        sel_d  = 8'hFF;
        seg_d  = 8'hFF;
        if (En && !shadow_blank_q[idx_q]) begin
            sel_d = ~(8'h01 << idx_q);
            seg_d = {~shadow_dp_q[idx_q], decode(nibble)};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt_q      <= '0;
            idx_q          <= 3'd0;
            load_pending_q <= 1'b1;
            shadow_data_q  <= 32'h0;
            shadow_blank_q <= 8'h0;
            shadow_dp_q    <= 8'h0;
            sel_q          <= 8'hFF;
            seg_q          <= 8'hFF;
        end else begin
            div_cnt_q      <= div_cnt_d;
            idx_q          <= idx_d;
            load_pending_q <= load_pending_d;
            shadow_data_q  <= shadow_data_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_dp_q    <= shadow_dp_d;
            sel_q          <= sel_d;
            seg_q          <= seg_d;
        end
    end

    assign SEL        = sel_q;
    assign SEG        = seg_q;
    // Pulse marks the snapshot cycle itself; held low while reset is asserted.
    assign Frame_Done = load && !Reset;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a frame-position reference model queues expected SEL/SEG per cycle,
// a negedge monitor pops and compares against two DUTs (dash and 'A' separator variants).
module tb_seg7_scan_driver;

    localparam int unsigned Div   = 3;
    localparam int          Slot  = Div + 1;
    localparam int          Frame = 8 * Slot;

    typedef struct packed {
        logic [7:0] sel1;
        logic [7:0] seg1;
        logic [7:0] sel0;
        logic [7:0] seg0;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        En = 1'b0;
    logic [31:0] data = 32'h0;
    logic [7:0]  bm = 8'h0;
    logic [7:0]  dm = 8'h0;
    logic [7:0]  sel1, seg1, sel0, seg0;
    logic        fd1, fd0;

    int checks = 0;
    int errors = 0;

    // Reference state: position within the scan since the last restart, plus snapshot.
    int          phase = 0;
    logic [31:0] s_data = 32'h0;
    logic [7:0]  s_blank = 8'h0;
    logic [7:0]  s_dp = 8'h0;
    exp_t        q[$];
    logic [6:0]  dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(.SCAN_DIV(Div), .SEP_AS_DASH(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Disp_Data(data), .Blank_Mask(bm),
        .Dp_Mask(dm), .SEL(sel1), .SEG(seg1), .Frame_Done(fd1)
    );

    seg7_scan_driver #(.SCAN_DIV(Div), .SEP_AS_DASH(1'b0)) dut_a (
        .Clk(Clk), .Reset(Reset), .En(En), .Disp_Data(data), .Blank_Mask(bm),
        .Dp_Mask(dm), .SEL(sel0), .SEG(seg0), .Frame_Done(fd0)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit snap_now();
        return (phase == 0) || ((phase % Frame) == Frame - 1);
    endfunction

    function automatic exp_t model_out();
        exp_t       e;
        int         d;
        logic [3:0] nib;
        e = '1;
        if (En) begin
            d = (phase / Slot) % 8;
            if (!s_blank[d]) begin
                nib    = s_data[4*d +: 4];
                e.sel1 = ~(8'd1 << d);
                e.sel0 = e.sel1;
                e.seg1 = {~s_dp[d], (nib == 4'hA) ? 7'h3F : dec_tab[nib]};
                e.seg0 = {~s_dp[d], dec_tab[nib]};
            end
        end
        return e;
    endfunction

    // Model: at each edge, queue what the registered outputs will show next cycle.
    initial forever begin
        @(posedge Clk);
        if (Reset) begin
            q.delete();
            q.push_back('1);
            phase   = 0;
            s_data  = 32'h0;
            s_blank = 8'h0;
            s_dp    = 8'h0;
        end else begin
            q.push_back(model_out());
            if (En && snap_now()) begin
                s_data  = data;
                s_blank = bm;
                s_dp    = dm;
            end
            phase = En ? phase + 1 : 0;
        end
    end

    initial forever begin
        exp_t e;
        logic fd_exp;
        @(negedge Clk);
        e = '1;
        if (q.size() == 0) begin
            if (!Reset) begin
                checks++;
                errors++;
                $display("FAIL queue_underflow at %0t", $time);
            end
        end else begin
            e = q.pop_front();
        end
        if (Reset) e = '1;
        fd_exp = En && !Reset && snap_now();
        check("sel_dash", sel1, e.sel1);
        check("seg_dash", seg1, e.seg1);
        check("sel_hexa", sel0, e.sel0);
        check("seg_hexa", seg0, e.seg0);
        check("frame_done_dash", {7'b0, fd1}, {7'b0, fd_exp});
        check("frame_done_hexa", {7'b0, fd0}, {7'b0, fd_exp});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Advance until the model sits at relative frame position r; an expired budget is a failure.
    task automatic wait_pos(input int r);
        for (int i = 0; i < 3 * Frame; i++) begin
            step(1);
            if (En && (phase % Frame) == r) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_pos: position %0d not reached, got %0d", r, phase % Frame);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        data = 32'h7654_3210;
        En   = 1'b1;
        step(3);
        Reset = 1'b0;
        #1;
        check("first_frame_done", {7'b0, fd1}, 8'h01);
        step(1);
        check("basic_sel0", sel1, 8'hFE);
        check("basic_seg0", seg1, 8'hC0);
        step(4);
        check("basic_sel1", sel1, 8'hFD);
        check("basic_seg1", seg1, 8'hF9);
        step(70);

        // Hex and separator rendering
        data = 32'hFEDC_BA98;
        wait_pos(Frame - 1);
        wait_pos(2 * Slot + 1);
        check("dash_digit2", seg1, 8'hBF);
        check("hexa_digit2", seg0, 8'h88);
        step(40);

        // Tear-free update
        data = 32'h0;
        wait_pos(Frame - 1);
        wait_pos(3 * Slot);
        data = 32'h1111_1111;
        wait_pos(5 * Slot + 1);
        check("tear_old_digit5", seg1, 8'hC0);
        wait_pos(7 * Slot + 1);
        check("tear_old_digit7", seg1, 8'hC0);
        wait_pos(1);
        check("tear_new_digit0", seg1, 8'hF9);

        // Masks
        data = 32'h0;
        bm   = 8'h81;
        dm   = 8'h24;
        wait_pos(Frame - 1);
        wait_pos(1);
        check("blank_sel0", sel1, 8'hFF);
        check("blank_seg0", seg1, 8'hFF);
        wait_pos(2 * Slot + 1);
        check("dp_seg2", seg1, 8'h40);
        wait_pos(3 * Slot + 1);
        check("nodp_seg3", seg1, 8'hC0);
        step(40);

        // Enable drop and restart
        bm = 8'h0;
        dm = 8'h0;
        wait_pos(Frame - 1);
        wait_pos(4 * Slot);
        En = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("en_low_sel", sel1, 8'hFF);
            check("en_low_seg", seg1, 8'hFF);
        end
        En = 1'b1;
        #1;
        check("en_rise_frame_done", {7'b0, fd1}, 8'h01);
        step(1);
        check("en_rise_sel", sel1, 8'hFE);

        // Asynchronous reset mid-frame
        wait_pos(5 * Slot + 1);
        Reset = 1'b1;
        #1;
        check("reset_async_sel", sel1, 8'hFF);
        check("reset_async_seg", seg1, 8'hFF);
        step(2);
        Reset = 1'b0;
        step(2);
        check("reset_restart_sel", sel1, 8'hFE);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) data = $urandom;
            if ($urandom_range(15) == 0) bm = 8'($urandom);
            if ($urandom_range(15) == 0) dm = 8'($urandom);
            if ($urandom_range(39) == 0) En = ~En;
            if ($urandom_range(299) == 0) begin
                Reset = 1'b1;
                step(1);
                Reset = 1'b0;
            end
            step(1);
        end

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the 8-digit seven-segment display.
- Consumes the 32-bit packed nibble word written by the clock/calendar logic and turns it into active-low digit select (SEL) and segment (SEG) lines.
- Snapshots the input word once per frame so a digit never changes mid-frame (no tearing).
- Decodes hex nibbles and renders separator code 0xA as a dash.
- Sits between the time-keeping core and the board pins.

Parameters:
- SCAN_DIV, 49_999: clock cycles per digit minus 1. At 50 MHz this gives 1 ms per digit and an 8 ms frame.
- SEP_AS_DASH, 1: when 1, nibble 0xA displays '-'. When 0, it displays 'A'.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous reset, active-high.
- En  input  1  display enable. When low, all digits are dark and the scan is held.
- Disp_Data  input  32  packed digits; digit i = Disp_Data[4i+3:4i].
- Blank_Mask  input  8  bit i = 1 blanks digit i.
- Dp_Mask  input  8  bit i = 1 lights the decimal point of digit i.
- SEL  output  8  digit select, active-low one-hot; SEL[i] drives digit i.
- SEG  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- Frame_Done  output  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Reset values (asserted asynchronously, mid-frame included):
  - div_cnt = 0, idx = 0, all shadow registers = 0.
  - SEL = 8'hFF, SEG = 8'hFF, Frame_Done = 0.
  - load_pending = 1.
- Divider:
  - div_cnt counts 0..SCAN_DIV and wraps to 0.
  - tick = En && (div_cnt == SCAN_DIV).
- Digit index:
  - On tick, idx <= idx + 1 (3 bits, wraps 7 -> 0).
- Snapshot:
  - shadow_data, shadow_blank and shadow_dp load from the inputs in the cycle where (tick && idx == 7) or (load_pending && En).
  - Frame_Done = 1 in exactly that cycle; load_pending clears.
  - Input changes at any other time have no visible effect until the next snapshot.
- Output registers, updated every cycle from the current idx and shadow state:
  - SEL = ~(8'b1 << idx), except 8'hFF when shadow_blank[idx] = 1.
  - SEG[6:0] = decode(shadow_data nibble idx).
  - SEG[7] = ~shadow_dp[idx].
  - SEG = 8'hFF when the digit is blanked.
  - Latency: a change of idx or shadow appears on SEL/SEG one cycle later.
- Decode table (SEG[6:0] hex, active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, B:03, C:46, D:21, E:06, F:0E
  - When SEP_AS_DASH = 1, nibble A decodes to 3F (segment g only).
- En low:
  - div_cnt and idx are forced to 0; load_pending sets.
  - SEL and SEG are registered to 8'hFF; Frame_Done = 0.
  - On En rising, the first En-high cycle takes a snapshot and scanning restarts at digit 0.
- Simultaneous events:
  - tick with idx == 7 and load_pending both true gives one snapshot and a single Frame_Done pulse.
- Exactly one digit is active at a time. At most one SEL bit is low in any cycle.
- The wrap from digit 7 to digit 0 adds no extra dead cycle. Frame period = 8 * (SCAN_DIV + 1) cycles.

Test Plan:
- Basic scan (SCAN_DIV = 3, Disp_Data = 32'h7654_3210, masks 0, En = 1 from reset release):
  - SEL steps FE, FD, FB, ... 7F, FE with 4 cycles per digit.
  - SEG = C0, F9, A4, B0, 99, 92, 82, F8 in step with SEL.
  - Frame_Done pulses every 32 cycles.
- Separator and hex:
  - Disp_Data = 32'hFEDC_BA98 with SEP_AS_DASH = 1: digit 2 shows SEG = BF; the other digits show 80, 90, 83, C6, A1, 86, 8E.
  - Same data with SEP_AS_DASH = 0: digit 2 shows 88.
- Tear-free update:
  - Change Disp_Data from 32'h0000_0000 to 32'h1111_1111 while digit 3 is active.
  - Digits 3..7 of the current frame still show C0.
  - All digits show F9 only after the next Frame_Done.
- Masks:
  - Blank_Mask = 8'h81, Dp_Mask = 8'h24, data all zero.
  - Digits 0 and 7 have SEL = FF and SEG = FF during their slots.
  - Digits 2 and 5 show SEG = 40; all other digits show C0.
- Enable and reset mid-frame:
  - Drop En at digit 4: SEL = SEG = FF one cycle later and stay there while En is low.
  - Raise En: Frame_Done pulses on the first En-high cycle and digit 0 is shown next.
  - Assert Reset at digit 5: SEL = SEG = FF immediately (asynchronous); after release, scanning restarts at digit 0.
